// File: rtl/spdot_bsr_lanes_pkg.sv
// -----------------------------------------------------------------------------
// spdot_pkg
// Shared types and helpers for the spdot_bsr_lanes sparse-attention score
// engine: FSM state encoding, checksum width and ACC_W -> 64 sign extension.
// -----------------------------------------------------------------------------
package spdot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_EMIT,
        ST_DONE
    } spdot_state_e;

    localparam int unsigned CSUM_W = 64;

    // Sign-extends the low acc_w bits of v to CSUM_W bits (acc_w <= CSUM_W).
    function automatic logic [CSUM_W-1:0] sext_acc(input logic [CSUM_W-1:0] v,
                                                   input int unsigned       acc_w);
        logic [CSUM_W-1:0] t;
        t = v << (CSUM_W - acc_w);
        return CSUM_W'($signed(t) >>> (CSUM_W - acc_w));
    endfunction

endpackage

// File: rtl/spdot_bsr_lanes_if.sv
// -----------------------------------------------------------------------------
// spdot_bsr_lanes_if
// Score result stream (valid/ready) between spdot_bsr_lanes and the softmax
// consumer.
//   res_valid  score valid (producer)
//   res_ready  consumer ready (consumer)
//   res_data   signed ACC_W-bit score
//   res_row    query row index of the score
//   res_tok    key token index of the score
// Modports: master = score producer, slave = score consumer.
// -----------------------------------------------------------------------------
interface spdot_bsr_lanes_if #(
    parameter int unsigned ACC_W = 48
);
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic [15:0]      res_row;
    logic [15:0]      res_tok;

    modport master (
        output res_valid,
        output res_data,
        output res_row,
        output res_tok,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_row,
        input  res_tok,
        output res_ready
    );
endinterface

// File: rtl/spdot_lane_dot.sv
// -----------------------------------------------------------------------------
// spdot_lane_dot
// Combinational LANES-wide signed dot product of one Q word and one K word.
//   q_word, k_word  LANES packed signed DATA_W elements, lane 0 in LSBs
//   lane_en         per-lane enable; disabled lanes contribute 0
//   dot             signed sum of enabled products, sign-extended to ACC_W
// The sum is written as a linear chain; synthesis rebalances it into a tree.
// -----------------------------------------------------------------------------
module spdot_lane_dot #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 4,
    parameter int unsigned ACC_W  = 48
) (
    input  logic [LANES*DATA_W-1:0] q_word,
    input  logic [LANES*DATA_W-1:0] k_word,
    input  logic [LANES-1:0]        lane_en,
    output logic signed [ACC_W-1:0] dot
);
    logic signed [DATA_W-1:0]   qe;
    logic signed [DATA_W-1:0]   ke;
    logic signed [2*DATA_W-1:0] prod;

    always_comb begin
        dot  = '0;
        qe   = '0;
        ke   = '0;
        prod = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            qe   = q_word[l*DATA_W +: DATA_W];
            ke   = k_word[l*DATA_W +: DATA_W];
            prod = qe * ke;
            if (lane_en[l]) begin
                dot = dot + ACC_W'(prod);
            end
        end
    end
endmodule

// File: rtl/spdot_bsr_lanes.sv
// -----------------------------------------------------------------------------
// spdot_bsr_lanes
// For every (row, token) pair computes a LANES-wide signed dot product over
// head_dim from the Q/K scratchpads (fixed read latency RD_LAT), emits each
// score on a valid/ready stream and keeps a 64-bit running checksum.
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   start                   begin job (sampled only in IDLE)
//   m_rows, s_tokens,
//   head_dim_d              job dimensions, captured at start
//   q_raddr/q_rdata         Q scratchpad read (word = row*beats + b)
//   k_raddr/k_rdata         K scratchpad read (word = tok*beats + b)
//   res                     score stream (spdot_bsr_lanes_if.master)
//   busy                    high outside IDLE
//   done                    one-cycle pulse at job end
//   checksum_out            checksum of the last completed job
// Optional build macro SPDOT_BSR_SKIP_EN adds blk_mask[31:0]: tokens whose
// block (tok/BLK_TOKENS) has a clear mask bit are skipped.
// -----------------------------------------------------------------------------
module spdot_bsr_lanes
    import spdot_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LANES      = 4,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned ACC_W      = 48,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned BLK_TOKENS = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [15:0]             m_rows,
    input  logic [15:0]             s_tokens,
    input  logic [15:0]             head_dim_d,
`ifdef SPDOT_BSR_SKIP_EN
    input  logic [31:0]             blk_mask,
`endif
    output logic [ADDR_W-1:0]       q_raddr,
    input  logic [LANES*DATA_W-1:0] q_rdata,
    output logic [ADDR_W-1:0]       k_raddr,
    input  logic [LANES*DATA_W-1:0] k_rdata,
    spdot_bsr_lanes_if.master       res,
    output logic                    busy,
    output logic                    done,
    output logic [CSUM_W-1:0]       checksum_out
);
    if (RD_LAT < 1 || RD_LAT > 4 || BLK_TOKENS < 1) begin : g_bad_param
        $error("spdot_bsr_lanes: RD_LAT must be 1..4 and BLK_TOKENS >= 1");
    end

    spdot_state_e state_q, state_d;

    logic [15:0]             m_r, s_r, d_r, beats_r;
    logic [15:0]             row, tok, b;
    logic [31:0]             elem;
    logic [ADDR_W-1:0]       q_base, k_base, beats_a;
    logic [ACC_W-1:0]        acc;
    logic [CSUM_W-1:0]       checksum;
    logic [2:0]              drain_cnt;
    logic                    vld_sr [RD_LAT];
    logic [LANES-1:0]        msk_sr [RD_LAT];
    logic [LANES-1:0]        lane_en_issue;
    logic signed [ACC_W-1:0] dot;
    logic [15:0]             beats_in;

    logic accept, zero_job, issue, last_beat, last_pair, hs, adv, skip_tok;

    assign beats_in  = (head_dim_d / 16'(LANES))
                     + {15'd0, (head_dim_d % 16'(LANES)) != 16'd0};
    assign beats_a   = ADDR_W'(beats_r);
    assign zero_job  = (m_rows == 16'd0) || (s_tokens == 16'd0) || (head_dim_d == 16'd0);
    assign last_beat = (b == beats_r - 16'd1);
    assign last_pair = (row == m_r - 16'd1) && (tok == s_r - 16'd1);

`ifdef SPDOT_BSR_SKIP_EN
    logic [31:0] blk_mask_r;
    logic [15:0] blk_idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk_mask_r <= '0;
        end else if (accept) begin
            blk_mask_r <= blk_mask;
        end
    end

    // Blocks beyond the 32 mask bits are always processed.
    assign blk_idx  = tok / 16'(BLK_TOKENS);
    assign skip_tok = (b == 16'd0) && (blk_idx < 16'd32) && !blk_mask_r[blk_idx[4:0]];
`else
    assign skip_tok = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        hs      = 1'b0;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = zero_job ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (skip_tok) begin
                    adv     = 1'b1;
                    state_d = last_pair ? ST_DONE : ST_ISSUE;
                end else begin
                    issue = 1'b1;
                    if (last_beat) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 3'(RD_LAT - 1)) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (res.res_ready) begin
                    hs      = 1'b1;
                    adv     = 1'b1;
                    state_d = last_pair ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Lanes past head_dim in the final beat are masked at issue time and the
    // mask travels with the read through the latency pipe.
    always_comb begin
        lane_en_issue = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_en_issue[l] = (elem + 32'(l)) < {16'd0, d_r};
        end
    end

    spdot_lane_dot #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) u_lane_dot (
        .q_word  (q_rdata),
        .k_word  (k_rdata),
        .lane_en (msk_sr[RD_LAT-1]),
        .dot     (dot)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_r          <= '0;
            s_r          <= '0;
            d_r          <= '0;
            beats_r      <= '0;
            row          <= '0;
            tok          <= '0;
            b            <= '0;
            elem         <= '0;
            q_base       <= '0;
            k_base       <= '0;
            q_raddr      <= '0;
            k_raddr      <= '0;
            acc          <= '0;
            checksum     <= '0;
            checksum_out <= '0;
            drain_cnt    <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                vld_sr[i] <= 1'b0;
                msk_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= issue;
            msk_sr[0] <= lane_en_issue;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                msk_sr[i] <= msk_sr[i-1];
            end

            if (vld_sr[RD_LAT-1]) begin
                acc <= acc + dot;
            end

            if (state_q == ST_DRAIN) begin
                drain_cnt <= drain_cnt + 3'd1;
            end

            if (issue) begin
                if (last_beat) begin
                    drain_cnt <= '0;
                end else begin
                    b       <= b + 16'd1;
                    elem    <= elem + 32'(LANES);
                    q_raddr <= q_raddr + 1'b1;
                    k_raddr <= k_raddr + 1'b1;
                end
            end

            if (hs) begin
                checksum <= checksum + sext_acc(CSUM_W'(acc), ACC_W);
                acc      <= '0;
            end

            // Bases track row*beats and tok*beats incrementally so no
            // multiplier is needed; addresses stay put after the last pair.
            if (adv && !last_pair) begin
                b    <= '0;
                elem <= '0;
                if (tok == s_r - 16'd1) begin
                    tok     <= '0;
                    row     <= row + 16'd1;
                    k_base  <= '0;
                    q_base  <= q_base + beats_a;
                    q_raddr <= q_base + beats_a;
                    k_raddr <= '0;
                end else begin
                    tok     <= tok + 16'd1;
                    k_base  <= k_base + beats_a;
                    q_raddr <= q_base;
                    k_raddr <= k_base + beats_a;
                end
            end

            if (accept) begin
                m_r      <= m_rows;
                s_r      <= s_tokens;
                d_r      <= head_dim_d;
                beats_r  <= beats_in;
                row      <= '0;
                tok      <= '0;
                b        <= '0;
                elem     <= '0;
                q_base   <= '0;
                k_base   <= '0;
                q_raddr  <= '0;
                k_raddr  <= '0;
                acc      <= '0;
                checksum <= '0;
            end

            if (state_q == ST_DONE) begin
                checksum_out <= checksum;
            end
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign res.res_valid = (state_q == ST_EMIT);
    assign res.res_data  = acc;
    assign res.res_row   = row;
    assign res.res_tok   = tok;

endmodule

// File: tb/tb_spdot_bsr_lanes.sv
// -----------------------------------------------------------------------------
// tb_spdot_bsr_lanes
// Directed self-checking bench for spdot_bsr_lanes with default parameters
// (LANES=4, DATA_W=16, RD_LAT=1). Scratchpads are modelled as registered
// 16-word memories giving one cycle of read latency.
// -----------------------------------------------------------------------------
module tb_spdot_bsr_lanes;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] m_rows = '0;
    logic [15:0] s_tokens = '0;
    logic [15:0] head_dim_d = '0;
    logic [15:0] q_raddr, k_raddr;
    logic [63:0] q_rdata, k_rdata;
    logic        busy, done;
    logic [63:0] checksum_out;

    logic [63:0] qmem [16];
    logic [63:0] kmem [16];

    logic [47:0] e_data [8];
    logic [15:0] e_row  [8];
    logic [15:0] e_tok  [8];
    logic [15:0] e_qa   [8];
    logic [15:0] e_ka   [8];

    int errors = 0;
    int checks = 0;
    int dcount;

    spdot_bsr_lanes_if #(.ACC_W(48)) res_if ();

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        q_rdata <= qmem[q_raddr[3:0]];
        k_rdata <= kmem[k_raddr[3:0]];
    end

    spdot_bsr_lanes #(
        .DATA_W     (16),
        .LANES      (4),
        .ADDR_W     (16),
        .ACC_W      (48),
        .RD_LAT     (1),
        .BLK_TOKENS (16)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .m_rows       (m_rows),
        .s_tokens     (s_tokens),
        .head_dim_d   (head_dim_d),
`ifdef SPDOT_BSR_SKIP_EN
        .blk_mask     (32'hFFFF_FFFF),
`endif
        .q_raddr      (q_raddr),
        .q_rdata      (q_rdata),
        .k_raddr      (k_raddr),
        .k_rdata      (k_rdata),
        .res          (res_if),
        .busy         (busy),
        .done         (done),
        .checksum_out (checksum_out)
    );

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input int i, input logic [47:0] d, input logic [15:0] r,
                           input logic [15:0] t, input logic [15:0] qa, input logic [15:0] ka);
        e_data[i] = d;
        e_row[i]  = r;
        e_tok[i]  = t;
        e_qa[i]   = qa;
        e_ka[i]   = ka;
    endtask

    task automatic go(input logic [15:0] m, input logic [15:0] s, input logic [15:0] d);
        @(negedge clk);
        m_rows     = m;
        s_tokens   = s;
        head_dim_d = d;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_res(input string tag, input int i);
        chk({tag, "_data"}, 64'(res_if.res_data), 64'(e_data[i]));
        chk({tag, "_row"},  64'(res_if.res_row),  64'(e_row[i]));
        chk({tag, "_tok"},  64'(res_if.res_tok),  64'(e_tok[i]));
        chk({tag, "_qa"},   64'(q_raddr),         64'(e_qa[i]));
        chk({tag, "_ka"},   64'(k_raddr),         64'(e_ka[i]));
    endtask

    // Consumes results until done (bounded), stalling result stall_idx for
    // stall_len cycles, then checks the done pulse width and the checksum.
    task automatic collect(input int stall_idx, input int stall_len, input int n_exp,
                           input logic [63:0] exp_csum);
        int  n;
        int  stall;
        bit  got;
        n     = 0;
        stall = 0;
        got   = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (res_if.res_valid) begin
                if (n == stall_idx && stall < stall_len) begin
                    res_if.res_ready = 1'b0;
                    check_res($sformatf("hold%0d_%0d", n, stall), n);
                    stall++;
                end else begin
                    res_if.res_ready = 1'b1;
                    if (n < 8) check_res($sformatf("res%0d", n), n);
                    n++;
                end
            end else begin
                res_if.res_ready = 1'b1;
            end
        end
        res_if.res_ready = 1'b1;
        chk("job_done", 64'(got), 64'd1);
        chk("n_results", 64'(n), 64'(n_exp));
        @(negedge clk);
        chk("done_pulse_end", 64'(done), 64'd0);
        chk("checksum", checksum_out, exp_csum);
        chk("idle_after_job", 64'(busy), 64'd0);
    endtask

    initial begin
        res_if.res_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            qmem[i] = '0;
            kmem[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(res_if.res_valid), 64'd0);
        chk("rst_data", 64'(res_if.res_data), 64'd0);
        chk("rst_qaddr", 64'(q_raddr), 64'd0);
        chk("rst_csum", checksum_out, 64'd0);
        rstn = 1'b1;

        // Job 1: m=1 s=1 d=4 -> 70 with exact latency
        qmem[0] = pack4(1, 2, 3, 4);
        kmem[0] = pack4(5, 6, 7, 8);
        go(16'd1, 16'd1, 16'd4);
        chk("t1_busy_issue", 64'(busy), 64'd1);
        chk("t1_valid_issue", 64'(res_if.res_valid), 64'd0);
        chk("t1_qaddr_issue", 64'(q_raddr), 64'd0);
        @(negedge clk);
        chk("t1_valid_drain", 64'(res_if.res_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid_emit", 64'(res_if.res_valid), 64'd1);
        chk("t1_data", 64'(res_if.res_data), 64'd70);
        chk("t1_row", 64'(res_if.res_row), 64'd0);
        chk("t1_tok", 64'(res_if.res_tok), 64'd0);
        @(negedge clk);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_valid_done", 64'(res_if.res_valid), 64'd0);
        @(negedge clk);
        chk("t1_done_end", 64'(done), 64'd0);
        chk("t1_csum", checksum_out, 64'd70);
        chk("t1_idle", 64'(busy), 64'd0);

        // Job 2: d=6, garbage in beat-1 lanes 2-3 must be ignored -> 12
        qmem[0] = pack4(1, 1, 1, 1);
        qmem[1] = pack4(1, 1, 32767, 32767);
        kmem[0] = pack4(2, 2, 2, 2);
        kmem[1] = pack4(2, 2, 32767, 32767);
        set_exp(0, 48'd12, 16'd0, 16'd0, 16'd1, 16'd1);
        go(16'd1, 16'd1, 16'd6);
        collect(-1, 0, 1, 64'd12);

        // Job 3: d=1, -3 * 7 = -21
        qmem[0] = pack4(-3, 32767, 32767, 32767);
        kmem[0] = pack4(7, 32767, 32767, 32767);
        set_exp(0, 48'hFFFF_FFFF_FFEB, 16'd0, 16'd0, 16'd0, 16'd0);
        go(16'd1, 16'd1, 16'd1);
        collect(-1, 0, 1, 64'hFFFF_FFFF_FFFF_FFEB);

        // Job 4: m=2 s=3 d=4, second result stalled for 5 cycles
        qmem[0] = pack4(1, 2, 3, 4);
        qmem[1] = pack4(-1, 0, 2, 1);
        kmem[0] = pack4(5, 6, 7, 8);
        kmem[1] = pack4(1, 1, 1, 1);
        kmem[2] = pack4(-2, 3, 0, 1);
        set_exp(0, 48'd70, 16'd0, 16'd0, 16'd0, 16'd0);
        set_exp(1, 48'd10, 16'd0, 16'd1, 16'd0, 16'd1);
        set_exp(2, 48'd8,  16'd0, 16'd2, 16'd0, 16'd2);
        set_exp(3, 48'd17, 16'd1, 16'd0, 16'd1, 16'd0);
        set_exp(4, 48'd2,  16'd1, 16'd1, 16'd1, 16'd1);
        set_exp(5, 48'd3,  16'd1, 16'd2, 16'd1, 16'd2);
        go(16'd2, 16'd3, 16'd4);
        collect(1, 5, 6, 64'd110);

        // Job 5: s_tokens=0 -> straight to DONE, checksum 0
        go(16'd1, 16'd0, 16'd4);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_busy", 64'(busy), 64'd1);
        chk("t5_valid", 64'(res_if.res_valid), 64'd0);
        @(negedge clk);
        chk("t5_done_end", 64'(done), 64'd0);
        chk("t5_csum", checksum_out, 64'd0);

        // Job 6: start while busy is ignored
        set_exp(0, 48'd70, 16'd0, 16'd0, 16'd0, 16'd0);
        go(16'd1, 16'd1, 16'd4);
        m_rows   = 16'd2;
        s_tokens = 16'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect(-1, 0, 1, 64'd70);

        // Reset during ISSUE aborts without a done pulse
        go(16'd1, 16'd1, 16'd16);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_done", 64'(done), 64'd0);
        chk("ar_valid", 64'(res_if.res_valid), 64'd0);
        chk("ar_data", 64'(res_if.res_data), 64'd0);
        chk("ar_qaddr", 64'(q_raddr), 64'd0);
        chk("ar_kaddr", 64'(k_raddr), 64'd0);
        chk("ar_csum", checksum_out, 64'd0);
        rstn   = 1'b1;
        dcount = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("ar_no_done", 64'(dcount), 64'd0);

        set_exp(0, 48'd70, 16'd0, 16'd0, 16'd0, 16'd0);
        go(16'd1, 16'd1, 16'd4);
        collect(-1, 0, 1, 64'd70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
